// File: rtl/sbox_col_collect.sv
// Collects one masked S-box output column per transfer into a 2-entry skid FIFO,
// tags it with its column index and forwards it; define SBOX_COL_REFRESH_EN to re-mask on write.
module sbox_col_collect #(
  parameter int d = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [32*d-1:0]   in_sbox,
`ifdef SBOX_COL_REFRESH_EN
  input  logic [32*(d-1)-1:0] rnd_refresh,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [32*d-1:0]   out_col,
  output logic [1:0]        out_idx,
  output logic              out_last
);

  localparam int W = 32 * d;

  // Handshake: a transfer happens on a rising edge where valid & ready are both high;
  // a producer holding valid keeps its data stable until ready, and ready never depends on valid.

  logic [W-1:0] mem_data [2];
  logic [1:0]   mem_idx  [2];
  logic         wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [1:0]   count, count_nxt;
  logic [1:0]   col_cnt, col_cnt_nxt;
  logic [W-1:0] head_data, head_data_nxt;
  logic [1:0]   head_idx, head_idx_nxt;
  logic [W-1:0] wdata;
  logic         wr_en, rd_en;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign wr_en     = in_valid & in_ready & ~flush;
  assign rd_en     = out_valid & out_ready & ~flush;

  // Share-wise re-masking; the last share absorbs the XOR of all fresh masks so the
  // unmasked value is untouched. Each bit is refreshed independently of the others.
  always_comb begin
    wdata = in_sbox;
`ifdef SBOX_COL_REFRESH_EN
    for (int i = 0; i < 32; i++) begin
      logic acc;
      acc = 1'b0;
      for (int s = 0; s < d - 1; s++) begin
        wdata[i*d+s] = in_sbox[i*d+s] ^ rnd_refresh[i*(d-1)+s];
        acc          = acc ^ rnd_refresh[i*(d-1)+s];
      end
      wdata[i*d+d-1] = in_sbox[i*d+d-1] ^ acc;
    end
`endif
  end

  always_comb begin
    wr_ptr_nxt    = wr_ptr;
    rd_ptr_nxt    = rd_ptr;
    count_nxt     = count;
    col_cnt_nxt   = col_cnt;
    head_data_nxt = head_data;
    head_idx_nxt  = head_idx;
    if (flush) begin
      wr_ptr_nxt  = 1'b0;
      rd_ptr_nxt  = 1'b0;
      count_nxt   = 2'd0;
      col_cnt_nxt = 2'd0;
    end else begin
      if (wr_en) begin
        wr_ptr_nxt  = ~wr_ptr;
        col_cnt_nxt = col_cnt + 2'd1;
      end
      if (rd_en) rd_ptr_nxt = ~rd_ptr;
      count_nxt = count + 2'(wr_en) - 2'(rd_en);
    end
    // The output register mirrors the head entry; when the FIFO drains it keeps the last column.
    if (count_nxt != 2'd0) begin
      if (wr_en && (wr_ptr == rd_ptr_nxt)) begin
        head_data_nxt = wdata;
        head_idx_nxt  = col_cnt;
      end else begin
        head_data_nxt = mem_data[rd_ptr_nxt];
        head_idx_nxt  = mem_idx[rd_ptr_nxt];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mem_data[i] <= '0;
        mem_idx[i]  <= '0;
      end
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
      col_cnt   <= 2'd0;
      head_data <= '0;
      head_idx  <= '0;
    end else begin
      if (wr_en) begin
        mem_data[wr_ptr] <= wdata;
        mem_idx[wr_ptr]  <= col_cnt;
      end
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      count     <= count_nxt;
      col_cnt   <= col_cnt_nxt;
      head_data <= head_data_nxt;
      head_idx  <= head_idx_nxt;
    end
  end

  assign out_col  = head_data;
  assign out_idx  = head_idx;
  assign out_last = (head_idx == 2'd3);

endmodule

// File: tb/tb_sbox_col_collect.sv
// Directed bench for sbox_col_collect (d=2): reset, streaming, backpressure, index wrap,
// flush, optional refresh build (SBOX_COL_REFRESH_EN) and asynchronous reset mid-stream.
module tb_sbox_col_collect;

  localparam int D = 2;
  localparam int W = 32 * D;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_sbox;
  logic [31:0]  rnd_refresh;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_col;
  logic [1:0]   out_idx;
  logic         out_last;

  int n_tests = 0;
  int n_fail  = 0;

  sbox_col_collect #(.d(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sbox    (in_sbox),
`ifdef SBOX_COL_REFRESH_EN
    .rnd_refresh(rnd_refresh),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_col    (out_col),
    .out_idx    (out_idx),
    .out_last   (out_last)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // share0 = mask, share1 = value ^ mask, interleaved per bit
  function automatic logic [63:0] make_col(input logic [31:0] v, input logic [31:0] m);
    logic [63:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c[2*i]   = m[i];
      c[2*i+1] = v[i] ^ m[i];
    end
    return c;
  endfunction

  function automatic logic [31:0] unmask(input logic [63:0] c);
    logic [31:0] u;
    for (int i = 0; i < 32; i++) u[i] = c[2*i] ^ c[2*i+1];
    return u;
  endfunction

  logic [31:0] t2_val  [4] = '{32'h63636363, 32'h7C7C7C7C, 32'h77777777, 32'h7B7B7B7B};
  logic [31:0] t2_mask [4] = '{32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C, 32'hDEADBEEF};
  logic [1:0]  t4_idx  [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  initial begin
    logic [63:0] col_a, col_b, col_c, col_d, col_k;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_sbox = '0;
    rnd_refresh = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // T1 reset / empty
    check("t1_out_valid", out_valid, 0);
    check("t1_in_ready",  in_ready,  1);
    check("t1_out_col",   out_col,   0);
    check("t1_out_idx",   out_idx,   0);
    check("t1_out_last",  out_last,  0);

    // T2 streaming
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      in_valid = 1'b1;
      in_sbox  = make_col(t2_val[j], t2_mask[j]);
      tick();
      check("t2_valid",  out_valid, 1);
      check("t2_ready",  in_ready,  1);
      check("t2_idx",    out_idx,   j);
      check("t2_last",   out_last,  (j == 3));
      check("t2_col",    out_col,   make_col(t2_val[j], t2_mask[j]));
      check("t2_unmask", unmask(out_col), t2_val[j]);
    end
    in_valid = 1'b0;
    tick();
    check("t2_drained", out_valid, 0);
    check("t2_hold",    out_col,   make_col(t2_val[3], t2_mask[3]));

    // T3 backpressure (col_cnt is back to 0)
    col_a = make_col(32'hA0A1A2A3, 32'h11111111);
    col_b = make_col(32'hB0B1B2B3, 32'h22222222);
    col_c = make_col(32'hC0C1C2C3, 32'h33333333);
    out_ready = 1'b0;
    in_valid = 1'b1; in_sbox = col_a; tick();
    check("t3_ready1", in_ready, 1);
    in_sbox = col_b; tick();
    check("t3_ready2", in_ready, 0);
    in_sbox = col_c; tick();
    check("t3_held_ready", in_ready, 0);
    check("t3_head_a",     out_col,  col_a);
    check("t3_head_a_idx", out_idx,  0);
    out_ready = 1'b1; tick();
    check("t3_head_b",     out_col,  col_b);
    check("t3_head_b_idx", out_idx,  1);
    check("t3_ready3",     in_ready, 1);
    tick();
    check("t3_head_c",     out_col,   col_c);
    check("t3_head_c_idx", out_idx,   2);
    check("t3_c_valid",    out_valid, 1);
    in_valid = 1'b0; tick();
    check("t3_empty", out_valid, 0);

    // T4 index wrap, starting from a cleared counter
    flush = 1'b1; tick(); flush = 1'b0;
    for (int k = 0; k < 6; k++) begin
      col_k = make_col(32'h01020304 * (k + 1), 32'h5A5A0000 + k);
      in_valid = 1'b1; in_sbox = col_k; tick();
      check("t4_idx",  out_idx,  t4_idx[k]);
      check("t4_col",  out_col,  col_k);
      check("t4_last", out_last, (t4_idx[k] == 2'd3));
    end
    in_valid = 1'b0; tick();

    // T5 flush while full with col_cnt=2, flush beats a concurrent write
    flush = 1'b1; tick(); flush = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_sbox = col_a; tick();
    in_sbox = col_b; tick();
    check("t5_full", in_ready, 0);
    flush = 1'b1; out_ready = 1'b1; in_sbox = col_c; tick();
    flush = 1'b0; in_valid = 1'b0;
    check("t5_flush_valid", out_valid, 0);
    check("t5_flush_ready", in_ready,  1);
    tick();
    check("t5_nothing_written", out_valid, 0);
    col_d = make_col(32'hD0D1D2D3, 32'h44444444);
    in_valid = 1'b1; in_sbox = col_d; tick();
    check("t5_next_valid", out_valid, 1);
    check("t5_next_idx",   out_idx,   0);
    check("t5_next_col",   out_col,   col_d);
    in_valid = 1'b0; tick();

`ifdef SBOX_COL_REFRESH_EN
    // T6 refresh: shares 0 / 0x0000FFFF re-masked with 0xA5A5A5A5
    in_valid = 1'b1; in_sbox = make_col(32'h0000FFFF, 32'h00000000);
    rnd_refresh = 32'hA5A5A5A5; tick();
    in_valid = 1'b0; rnd_refresh = '0;
    check("t6_col",    out_col, make_col(32'hA5A55A5A ^ 32'hA5A5A5A5, 32'hA5A5A5A5));
    check("t6_unmask", unmask(out_col), 32'h0000FFFF);
    tick();
`endif

    // T7 asynchronous reset with two columns buffered
    out_ready = 1'b0;
    in_valid = 1'b1; in_sbox = col_a; tick();
    in_sbox = col_b; tick();
    in_valid = 1'b0;
    check("t7_full", in_ready, 0);
    #2 rst = 1'b1;
    #1;
    check("t7_valid", out_valid, 0);
    check("t7_ready", in_ready,  1);
    check("t7_col",   out_col,   0);
    check("t7_idx",   out_idx,   0);
    tick();
    rst = 1'b0;
    in_valid = 1'b1; in_sbox = col_c; tick();
    in_valid = 1'b0;
    check("t7_after_valid", out_valid, 1);
    check("t7_after_idx",   out_idx,   0);
    check("t7_after_col",   out_col,   col_c);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
